topic_sampler: RTL and testbench

- Downstream consumer of the per-topic count memories in the Gibbs-sampling LDA datapath.
- For one token, accepts each topic's (nw, nw_sum, nd) counts streamed in topic order and computes a fixed-point conditional weight per topic.
- Draws a pseudo-random point in the cumulative weight distribution and returns the selected topic to all topic memories as new_topic with a valid strobe.

---
 rtl/topic_sampler_if.sv | 25 ++
 rtl/topic_sampler.sv | 183 ++++++++++++++++++
 tb/tb_topic_sampler.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/topic_sampler_if.sv
// Count-stream and selected-topic signals between the topic count
// memories (master) and the topic sampler (slave).
`timescale 1ns/1ps
interface topic_sampler_if;
    logic        i_start;
    logic        i_k_valid;
    logic [31:0] i_nw;
    logic [31:0] i_nw_sum;
    logic [31:0] i_nd;
    logic        o_k_ready;
    logic [5:0]  o_k_idx;
    logic [31:0] o_new_topic;
    logic        o_topic_valid;
    logic        o_busy;

    modport master (
        output i_start, i_k_valid, i_nw, i_nw_sum, i_nd,
        input  o_k_ready, o_k_idx, o_new_topic, o_topic_valid, o_busy
    );

    modport slave (
        input  i_start, i_k_valid, i_nw, i_nw_sum, i_nd,
        output o_k_ready, o_k_idx, o_new_topic, o_topic_valid, o_busy
    );
endinterface

// File: rtl/topic_sampler.sv
// Gibbs LDA topic sampler: per-topic fixed-point weights, cumulative
// distribution, LFSR draw and linear scan for the new topic.
`timescale 1ns/1ps
module topic_sampler #(
    parameter int unsigned NUM_TOPICS = 4,
    parameter int unsigned ALPHA      = 1,
    parameter int unsigned BETA       = 1,
    parameter int unsigned VBETA      = 16384,
    parameter int unsigned FRAC_BITS  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
    input logic            clk,
    input logic            rst_n,
    topic_sampler_if.slave bus
);
    localparam int unsigned QW = 32 + FRAC_BITS;
    localparam int unsigned KW =
        (NUM_TOPICS > 1) ? $clog2(NUM_TOPICS) : 1;
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [5:0]  K_LAST   = 6'(NUM_TOPICS - 1);
    localparam logic [6:0]  CNT_LAST = 7'(QW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIV, S_ACC, S_DRAW, S_SCAN, S_OUT
    } state_t;

    state_t        r_state;
    logic [5:0]    r_k;
    logic [31:0]   r_total;
    logic [31:0]   r_den;
    logic [31:0]   r_u;
    logic [31:0]   r_lfsr;
    logic [QW-1:0] r_dq;
    logic [31:0]   r_rem;
    logic [6:0]    r_cnt;
    logic [31:0]   r_cum [NUM_TOPICS];
    logic          r_k_ready;
    logic [5:0]    r_k_idx;
    logic [31:0]   r_new_topic;
    logic          r_topic_valid;
    logic          r_busy;

    logic [32:0] w_nw_b;
    logic [32:0] w_nd_a;
    logic [65:0] w_prod;
    logic [31:0] w_num;
    logic [32:0] w_den_sum;
    logic [31:0] w_den;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nx;
    logic [63:0] w_q64;
    logic [31:0] w_w;
    logic [32:0] w_tot_sum;
    logic [31:0] w_tot_sat;
    logic [31:0] w_lfsr_nx;
    logic [63:0] w_draw;
    logic        w_hit;
    logic        w_unused;

    always_comb begin
        w_nw_b    = {1'b0, bus.i_nw} + 33'(BETA);
        w_nd_a    = {1'b0, bus.i_nd} + 33'(ALPHA);
        w_prod    = {33'b0, w_nw_b} * {33'b0, w_nd_a};
        w_num     = (|w_prod[65:32]) ? '1 : w_prod[31:0];
        w_den_sum = {1'b0, bus.i_nw_sum} + 33'(VBETA);
        w_den     = w_den_sum[32] ? '1 : w_den_sum[31:0];
        // Restoring step: remainder always stays below den
        w_rem_sh  = {r_rem, r_dq[QW-1]};
        w_diff    = w_rem_sh - {1'b0, r_den};
        w_qbit    = (w_rem_sh >= {1'b0, r_den});
        w_rem_nx  = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
        w_q64     = 64'(r_dq);
        w_w       = (|w_q64[63:32]) ? '1 : w_q64[31:0];
        w_tot_sum = {1'b0, r_total} + {1'b0, w_w};
        w_tot_sat = w_tot_sum[32] ? '1 : w_tot_sum[31:0];
        w_lfsr_nx = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'h0);
        w_draw    = {32'h0, w_lfsr_nx} * {32'h0, r_total};
        w_hit     = r_cum[r_k[KW-1:0]] > r_u;
        w_unused  = ^{w_draw[31:0], w_diff[32]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_total       <= '0;
            r_den         <= '0;
            r_u           <= '0;
            r_lfsr        <= LFSR_SEED;
            r_dq          <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_k_ready     <= 1'b0;
            r_k_idx       <= '0;
            r_new_topic   <= '0;
            r_topic_valid <= 1'b0;
            r_busy        <= 1'b0;
            for (int i = 0; i < NUM_TOPICS; i++) begin
                r_cum[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state   <= S_LOAD;
                        r_k       <= '0;
                        r_total   <= '0;
                        r_k_ready <= 1'b1;
                        r_k_idx   <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.i_k_valid) begin
                        r_dq      <= QW'(w_num) << FRAC_BITS;
                        r_den     <= w_den;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_k_ready <= 1'b0;
                        r_k_idx   <= '0;
                        r_state   <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_dq  <= {r_dq[QW-2:0], w_qbit};
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_total              <= w_tot_sat;
                    r_cum[r_k[KW-1:0]]   <= w_tot_sat;
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAW;
                    end else begin
                        r_k       <= r_k + 6'd1;
                        r_k_idx   <= r_k + 6'd1;
                        r_k_ready <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_DRAW: begin
                    r_lfsr  <= w_lfsr_nx;
                    r_u     <= w_draw[63:32];
                    r_k     <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    // Empty distribution falls back to topic 0
                    if (r_total == 32'h0) begin
                        r_new_topic   <= '0;
                        r_topic_valid <= 1'b1;
                        r_state       <= S_OUT;
                    end else if (w_hit || (r_k == K_LAST)) begin
                        r_new_topic   <= 32'(r_k);
                        r_topic_valid <= 1'b1;
                        r_state       <= S_OUT;
                    end else begin
                        r_k <= r_k + 6'd1;
                    end
                end
                S_OUT: begin
                    r_topic_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_k_ready     = r_k_ready;
    assign bus.o_k_idx       = r_k_idx;
    assign bus.o_new_topic   = r_new_topic;
    assign bus.o_topic_valid = r_topic_valid;
    assign bus.o_busy        = r_busy;
endmodule

// File: tb/tb_topic_sampler.sv
// Scoreboard bench for topic_sampler: default-parameter instance with a
// reference draw model, and an ALPHA=BETA=0, VBETA=1 instance.
`timescale 1ns/1ps
module tb_topic_sampler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    topic_sampler_if ifa ();
    topic_sampler_if ifb ();

    topic_sampler dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa));
    topic_sampler #(.ALPHA(0), .BETA(0), .VBETA(1)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_a = 0;
    int done_b = 0;
    int strobe_cyc = 0;
    int exp_a[$];
    int exp_b[$];
    int got_a[$];
    logic prev_va = 1'b0;
    logic prev_vb = 1'b0;
    logic [31:0] v_nw [4];
    logic [31:0] v_nd [4];
    logic [31:0] v_nws [4];
    logic [31:0] m_lfsr;
    int hist [4];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic mon(input bit b, input logic v, input logic [31:0] t,
                       input logic pv);
        int e;
        if (pv) begin
            checks++;
            if (v) begin
                errors++;
                $display("FAIL strobe_width dut_%0d valid=%0b required 0",
                         b, v);
            end
        end else if (v) begin
            checks++;
            e = -1;
            if (b) begin
                if (exp_b.size() != 0) e = exp_b.pop_front();
            end else begin
                if (exp_a.size() != 0) e = exp_a.pop_front();
            end
            if (e < 0) begin
                errors++;
                $display("FAIL unexpected_strobe dut_%0d topic=%0d", b, t);
            end else if (t !== 32'(e)) begin
                errors++;
                $display("FAIL new_topic dut_%0d got %0d required %0d",
                         b, t, e);
            end
            if (b) done_b++;
            else begin
                done_a++;
                got_a.push_back(int'(t));
            end
            strobe_cyc = cyc;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon(1'b0, ifa.o_topic_valid, ifa.o_new_topic, prev_va);
        mon(1'b1, ifb.o_topic_valid, ifb.o_new_topic, prev_vb);
        prev_va = ifa.o_topic_valid;
        prev_vb = ifb.o_topic_valid;
    end

    task automatic drv(input bit b, input logic s, input logic v,
                       input int k);
        if (b) begin
            ifb.i_start = s; ifb.i_k_valid = v;
            ifb.i_nw = v_nw[k]; ifb.i_nd = v_nd[k]; ifb.i_nw_sum = v_nws[k];
        end else begin
            ifa.i_start = s; ifa.i_k_valid = v;
            ifa.i_nw = v_nw[k]; ifa.i_nd = v_nd[k]; ifa.i_nw_sum = v_nws[k];
        end
    endtask

    function automatic logic rdy(input bit b);
        return b ? ifb.o_k_ready : ifa.o_k_ready;
    endfunction

    function automatic logic [5:0] kidx(input bit b);
        return b ? ifb.o_k_idx : ifa.o_k_idx;
    endfunction

    function automatic logic busy(input bit b);
        return b ? ifb.o_busy : ifa.o_busy;
    endfunction

    task automatic wait_rdy(input bit b);
        int n;
        n = 0;
        while (!rdy(b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(b)) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut_%0d got 0 required 1", b);
        end
    endtask

    // Reference draw for the default-parameter instance
    function automatic int model_a();
        logic [63:0] num, w, tot, u;
        logic [31:0] cum [4];
        int sel;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            num = (64'(v_nw[k]) + 64'd1) * (64'(v_nd[k]) + 64'd1);
            if (num > 64'hFFFF_FFFF) num = 64'hFFFF_FFFF;
            w = (num << 16) / (64'(v_nws[k]) + 64'd16384);
            if (w > 64'hFFFF_FFFF) w = 64'hFFFF_FFFF;
            tot = tot + w;
            if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
            cum[k] = tot[31:0];
        end
        u = (64'(m_lfsr) * tot) >> 32;
        sel = 3;
        if (tot == 0) sel = 0;
        else begin
            for (int k = 3; k >= 0; k--) begin
                if (64'(cum[k]) > u) sel = k;
            end
        end
        return sel;
    endfunction

    task automatic run_token(input bit b, input int stall_k,
                             input int exp_t);
        int d0, t0, n, lat;
        if (b) exp_b.push_back(exp_t);
        else exp_a.push_back(exp_t);
        d0 = b ? done_b : done_a;
        @(posedge clk); #1 drv(b, 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        t0 = cyc;
        drv(b, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) begin
                wait_rdy(b);
                for (int s = 0; s < 5; s++) begin
                    chk("stall_ready", 32'(rdy(b)), 32'd1);
                    chk("stall_idx", 32'(kidx(b)), 32'(k));
                    @(posedge clk); #1 drv(b, s == 0, 1'b0, 0);
                    @(negedge clk);
                end
            end
            drv(b, 1'b0, 1'b1, k);
            wait_rdy(b);
            chk("k_idx", 32'(kidx(b)), 32'(k));
            @(posedge clk); #1 drv(b, 1'b0, 1'b0, 0);
        end
        n = 0;
        while ((b ? done_b : done_a) == d0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("token_done", 32'((b ? done_b : done_a) != d0), 32'd1);
        if (stall_k < 0 && (b ? done_b : done_a) != d0) begin
            lat = strobe_cyc - t0;
            chk("latency_in_range", 32'(lat >= 202 && lat <= 210), 32'd1);
        end
    endtask

    task automatic chk_idle(input bit b);
        if (b) begin
            chk("idle_k_ready", 32'(ifb.o_k_ready), 32'd0);
            chk("idle_k_idx", 32'(ifb.o_k_idx), 32'd0);
            chk("idle_new_topic", ifb.o_new_topic, 32'd0);
            chk("idle_topic_valid", 32'(ifb.o_topic_valid), 32'd0);
            chk("idle_busy", 32'(ifb.o_busy), 32'd0);
        end else begin
            chk("idle_k_ready", 32'(ifa.o_k_ready), 32'd0);
            chk("idle_k_idx", 32'(ifa.o_k_idx), 32'd0);
            chk("idle_new_topic", ifa.o_new_topic, 32'd0);
            chk("idle_topic_valid", 32'(ifa.o_topic_valid), 32'd0);
            chk("idle_busy", 32'(ifa.o_busy), 32'd0);
        end
    endtask

    task automatic pattern_a_ramp();
        v_nw  = '{32'd0, 32'd1, 32'd2, 32'd3};
        v_nd  = '{32'd0, 32'd0, 32'd0, 32'd0};
        v_nws = '{32'd0, 32'd0, 32'd0, 32'd0};
    endtask

    initial begin
        int d0;
        v_nw  = '{32'd0, 32'd0, 32'd0, 32'd0};
        v_nd  = '{32'd0, 32'd0, 32'd0, 32'd0};
        v_nws = '{32'd0, 32'd0, 32'd0, 32'd0};
        drv(1'b0, 1'b0, 1'b0, 0);
        drv(1'b1, 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk_idle(1'b0);
        chk_idle(1'b1);
        chk("idle_no_strobe", 32'(done_a + done_b), 32'd0);

        // Single hit on topic 2: w2 = 983040/11 = 89367
        v_nw  = '{32'd0, 32'd0, 32'd5, 32'd0};
        v_nd  = '{32'd0, 32'd0, 32'd3, 32'd0};
        v_nws = '{32'd0, 32'd0, 32'd10, 32'd0};
        run_token(1'b1, -1, 2);

        v_nw  = '{32'd0, 32'd0, 32'd0, 32'd7};
        v_nd  = '{32'd0, 32'd0, 32'd0, 32'd2};
        v_nws = '{32'd0, 32'd0, 32'd0, 32'd1};
        run_token(1'b1, -1, 3);

        v_nw  = '{32'd0, 32'd0, 32'd0, 32'd0};
        v_nd  = '{32'd9, 32'd9, 32'd9, 32'd9};
        v_nws = '{32'd4, 32'd4, 32'd4, 32'd4};
        run_token(1'b1, -1, 0);

        v_nw  = '{32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
        v_nd  = '{32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
        v_nws = '{32'd0, 32'd0, 32'd0, 32'd0};
        run_token(1'b1, -1, 1);

        v_nw  = '{32'd0, 32'd0, 32'd5, 32'd0};
        v_nd  = '{32'd0, 32'd0, 32'd3, 32'd0};
        v_nws = '{32'd0, 32'd0, 32'd10, 32'd0};
        run_token(1'b1, 2, 2);
        repeat (3) @(negedge clk);
        chk("busy_after_token", 32'(busy(1'b1)), 32'd0);
        chk("b_tokens", 32'(done_b), 32'd5);

        m_lfsr = 32'hACE1_0001;
        pattern_a_ramp();
        for (int i = 0; i < 8; i++) run_token(1'b0, -1, model_a());

        // Abort a token mid-divide
        @(posedge clk); #1 drv(1'b0, 1'b1, 1'b0, 0);
        @(posedge clk); #1 drv(1'b0, 1'b0, 1'b1, 0);
        wait_rdy(1'b0);
        @(posedge clk); #1 drv(1'b0, 1'b0, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("div_busy", 32'(busy(1'b0)), 32'd1);
        chk("div_k_ready", 32'(rdy(1'b0)), 32'd0);
        d0 = done_a;
        rst_a_n = 1'b0;
        @(negedge clk);
        chk_idle(1'b0);
        repeat (3) @(posedge clk);
        #1 rst_a_n = 1'b1;
        repeat (250) @(posedge clk);
        chk("abort_no_strobe", 32'(done_a), 32'(d0));
        chk("abort_idle", 32'(busy(1'b0)), 32'd0);

        m_lfsr = 32'hACE1_0001;
        for (int i = 0; i < 8; i++) run_token(1'b0, -1, model_a());

        // Equal weights: w = 4 per topic
        v_nw  = '{32'd0, 32'd0, 32'd0, 32'd0};
        v_nd  = '{32'd0, 32'd0, 32'd0, 32'd0};
        v_nws = '{32'd0, 32'd0, 32'd0, 32'd0};
        got_a.delete();
        for (int i = 0; i < 256; i++) run_token(1'b0, -1, model_a());
        chk("dist_tokens", 32'(got_a.size()), 32'd256);
        for (int i = 0; i < 4; i++) hist[i] = 0;
        foreach (got_a[i]) begin
            if (got_a[i] >= 0 && got_a[i] < 4) hist[got_a[i]]++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("dist_bucket_in_range",
                32'(hist[i] >= 36 && hist[i] <= 92), 32'd1);
        end
        chk("scoreboard_drained_a", 32'(exp_a.size()), 32'd0);
        chk("scoreboard_drained_b", 32'(exp_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
